// File: rtl/sccb_target.sv
// SCCB/I2C-style register target: 7-bit device address, 16-bit register pointer,
// burst writes and reads with pointer auto-increment, open-drain SDA via sda_t.
module sccb_target #(
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [3:0]  state_out
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] DEV_ADR  = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] REG_HI   = 4'd3;
    localparam logic [3:0] REG_LO   = 4'd4;
    localparam logic [3:0] WR_DATA  = 4'd5;
    localparam logic [3:0] WR_ACK   = 4'd6;
    localparam logic [3:0] RD_FETCH = 4'd7;
    localparam logic [3:0] RD_DATA  = 4'd8;
    localparam logic [3:0] RD_ACK   = 4'd9;
    localparam logic [3:0] IGNORE   = 4'd10;

    logic [1:0]  scl_sync, sda_sync;
    logic        scl_d, sda_d;
    logic [1:0]  warm;
    logic        scl_s, sda_s, ev_ok;
    logic        scl_rise, scl_fall, start_ev, stop_ev;

    logic [3:0]  state, ack_next;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg, byte_in, fetch_byte;
    logic [15:0] ptr, ptr_inc;
    logic        rw, ack_drv, have_data, last_bit;
    logic [3:0]  lat_cnt;

    assign sda_o     = 1'b0;
    assign state_out = state;

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            warm     <= 2'd0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    // Events are masked until the pipeline holds real pin values, so a bus caught
    // mid-transaction at reset release cannot fake a START from the reset-to-1 flops.
    always_comb begin
        scl_s    = scl_sync[1];
        sda_s    = sda_sync[1];
        ev_ok    = (warm == 2'd3);
        scl_rise = ev_ok & scl_s & ~scl_d;
        scl_fall = ev_ok & ~scl_s & scl_d;
        start_ev = ev_ok & scl_s & scl_d & sda_d & ~sda_s;
        stop_ev  = ev_ok & scl_s & scl_d & ~sda_d & sda_s;
        byte_in  = {shreg[6:0], sda_s};
        last_bit = (bit_cnt == 3'd7);
        ptr_inc  = ptr + 16'd1;
        // Read data may land in the same cycle as the SCL fall that launches the MSB
        fetch_byte = (lat_cnt == 4'd0 && !have_data) ? rd_data : shreg;
    end

    // Protocol state machine and all registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            ack_next  <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            ptr       <= 16'h0000;
            rw        <= 1'b0;
            ack_drv   <= 1'b0;
            have_data <= 1'b0;
            lat_cnt   <= 4'd0;
            sda_t     <= 1'b1;
            wr_valid  <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= 8'h00;
            rd_req    <= 1'b0;
            rd_addr   <= 16'h0000;
            busy      <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            if (stop_ev) begin
                state   <= IDLE;
                sda_t   <= 1'b1;
                bit_cnt <= 3'd0;
                ack_drv <= 1'b0;
                busy    <= 1'b0;
            end else if (start_ev) begin
                // Repeated START keeps the pointer and busy
                state   <= DEV_ADR;
                sda_t   <= 1'b1;
                bit_cnt <= 3'd0;
                ack_drv <= 1'b0;
            end else begin
                case (state)
                    DEV_ADR: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state <= ADDR_ACK;
                                rw    <= byte_in[0];
                                busy  <= 1'b1;
                            end else begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall && !ack_drv) begin
                            sda_t   <= 1'b0;
                            ack_drv <= 1'b1;
                        end else if (rw && scl_rise && ack_drv) begin
                            // Fetch during the ACK high phase; ACK stays driven until the fall
                            ack_drv   <= 1'b0;
                            state     <= RD_FETCH;
                            rd_req    <= 1'b1;
                            rd_addr   <= ptr;
                            lat_cnt   <= 4'(RD_LATENCY);
                            have_data <= 1'b0;
                        end else if (!rw && scl_fall && ack_drv) begin
                            ack_drv <= 1'b0;
                            sda_t   <= 1'b1;
                            state   <= REG_HI;
                        end
                    end
                    REG_HI, REG_LO, WR_DATA: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            state <= WR_ACK;
                            if (state == REG_HI) begin
                                ptr[15:8] <= byte_in;
                                ack_next  <= REG_LO;
                            end else if (state == REG_LO) begin
                                ptr[7:0] <= byte_in;
                                ack_next <= WR_DATA;
                            end else begin
                                wr_valid <= 1'b1;
                                wr_addr  <= ptr;
                                wr_data  <= byte_in;
                                ptr      <= ptr_inc;
                                ack_next <= WR_DATA;
                            end
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_t   <= 1'b0;
                            ack_drv <= 1'b1;
                        end else begin
                            sda_t   <= 1'b1;
                            ack_drv <= 1'b0;
                            state   <= ack_next;
                        end
                    end
                    RD_FETCH: begin
                        if (lat_cnt != 4'd0) begin
                            lat_cnt <= lat_cnt - 4'd1;
                        end else if (!have_data) begin
                            shreg     <= rd_data;
                            have_data <= 1'b1;
                        end
                        if (scl_fall) begin
                            shreg   <= fetch_byte;
                            sda_t   <= fetch_byte[7];
                            bit_cnt <= 3'd0;
                            state   <= RD_DATA;
                        end
                    end
                    RD_DATA: if (scl_fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            sda_t <= 1'b1;
                            state <= RD_ACK;
                        end else begin
                            sda_t <= shreg[6];
                            shreg <= {shreg[6:0], 1'b0};
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (!sda_s) begin
                            ptr       <= ptr_inc;
                            rd_req    <= 1'b1;
                            rd_addr   <= ptr_inc;
                            lat_cnt   <= 4'(RD_LATENCY);
                            have_data <= 1'b0;
                            state     <= RD_FETCH;
                        end else begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, the 7-bit bus address this target answers to.
REQ-002 SHALL have parameter RD_LATENCY, default 2, the number of cycles from rd_req to valid rd_data (range 1-8).
REQ-003 SHALL have port clk_in, input, 1: the single system clock.
REQ-004 SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port scl_i, input, 1: bus clock sampled from the pin (the target never drives SCL).
REQ-006 SHALL have port sda_i, input, 1: bus data sampled from the pin.
REQ-007 SHALL have port sda_o, output, 1: tied to 0.
REQ-008 SHALL have port sda_t, output, 1: 1 releases SDA; 0 pulls SDA low.
REQ-009 SHALL have port wr_valid, output, 1: one-cycle pulse that commits a register write.
REQ-010 SHALL have port wr_addr, output, 16: address of the register write.
REQ-011 SHALL have port wr_data, output, 8: data of the register write.
REQ-012 SHALL have port rd_req, output, 1: one-cycle pulse that requests a register read.
REQ-013 SHALL have port rd_addr, output, 16: read address, held stable from rd_req until the byte has been shifted out.
REQ-014 SHALL have port rd_data, input, 8: read data, valid exactly RD_LATENCY cycles after rd_req.
REQ-015 SHALL have port busy, output, 1: high from an addressed START until STOP or IDLE.
REQ-016 SHALL have port state_out, output, 4: current state encoding.

Function
REQ-017 SHALL pass scl_i and sda_i through 2-flop synchronizers and derive SCL rise/fall and START/STOP events from the synchronized signals only.
REQ-018 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both SHALL be honored in any state.
REQ-019 SHALL sample SDA on each SCL rise, shift bytes MSB first, and change sda_t only on the cycle after an SCL fall.
REQ-020 SHALL implement states IDLE, DEV_ADDR, ADDR_ACK, REG_HI, REG_LO, WR_DATA, WR_ACK, RD_FETCH, RD_DATA, RD_ACK, and IGNORE.
REQ-021 SHALL go IDLE->DEV_ADDR on START; a repeated START SHALL also return to DEV_ADDR, with the pointer kept.
REQ-022 SHALL, after 8 address bits, compare bits[7:1] to DEV_ADDR; on a match it SHALL go to ADDR_ACK and drive ACK (sda_t=0) for the 9th bit.
REQ-023 SHALL, on an address mismatch, go to IGNORE with sda_t held at 1 until the next START or STOP.
REQ-024 SHALL, after ADDR_ACK with R/W=0, go to REG_HI; with R/W=1 it SHALL go to RD_FETCH.
REQ-025 SHALL load REG_HI into pointer[15:8] and REG_LO into pointer[7:0]; each byte SHALL be ACKed via WR_ACK.
REQ-026 SHALL, for each further write byte, pulse wr_valid for one cycle on the 8th SCL rise with wr_addr=pointer and wr_data=byte, then increment the pointer, ACK, and remain in WR_DATA.
REQ-027 SHALL perform pointer increment modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-028 SHALL, in RD_FETCH, pulse rd_req with rd_addr=pointer, capture rd_data RD_LATENCY cycles later, and drive its MSB after the next SCL fall.
REQ-029 SHALL shift in RD_DATA the captured byte onto sda_t (bit=0 -> sda_t=0) and release SDA for the 9th bit (RD_ACK).
REQ-030 SHALL, in RD_ACK, sample the master's bit: ACK (0) increments the pointer and returns to RD_FETCH; NACK (1) goes to IGNORE.
REQ-031 SHALL, on STOP mid-byte, discard the partial byte, issue no wr_valid, release SDA, and go IDLE.
REQ-032 SHALL never assert wr_valid and rd_req in the same cycle.

Reset
REQ-033 SHALL, while rst_in=0, force IDLE, sda_t=1, sda_o=0, wr_valid=0, rd_req=0, busy=0, wr_addr=0, wr_data=0, rd_addr=0, the pointer to 0, and the synchronizers to 1.
REQ-034 SHALL, on reset assertion mid-transaction, release SDA asynchronously; after reset release it SHALL ignore bus activity until a fresh START.

Verification
REQ-035 SHALL be tested with a write of START, 0x78, 0x30, 0x08, 0x82, STOP -> four ACKs and exactly one wr_valid with wr_addr=0x3008 and wr_data=0x82.
REQ-036 SHALL be tested with START, 0x84, 0x30, STOP -> no ACK (SDA high on the 9th bit), no wr_valid, and state reaching IGNORE then IDLE.
REQ-037 SHALL be tested with START, 0x78, 0x30, 0x0A, repeated START, 0x79, rd_data=0x56, master NACK, STOP -> rd_req with rd_addr=0x300A and SDA bits 0,1,0,1,0,1,1,0.
REQ-038 SHALL be tested with a burst write to pointer 0xFFFF of data 0x11, 0x22 -> writes (0xFFFF,0x11) then (0x0000,0x22).
REQ-039 SHALL be tested with a burst read from 0x3000 with master ACK, ACK, NACK -> rd_addr values 0x3000, 0x3001, 0x3002, then IDLE after STOP.
REQ-040 SHALL be tested with STOP after 4 data bits, and separately rst_in pulsed low during RD_DATA -> no wr_valid, sda_t=1 immediately, and state IDLE.
